parallax_ctrl: RTL and testbench

Frame-synchronous configuration controller for the parallax-correction stage. It accepts a target horizontal parallax offset over a small register port and monitors the raw line stream that feeds the correction datapath. It applies the new offset to the datapath's `parallax_corr` input only in the gap after the last line of a frame, either as a single jump or as a ±1-per-frame ramp. This guarantees the correction never changes mid-line or mid-frame, so no frame tears.

---
 rtl/parallax_pkg.sv | 23 ++
 rtl/parallax_ctrl_if.sv | 21 ++
 rtl/prlx_line_tracker.sv | 75 +++++++
 rtl/parallax_ctrl.sv | 116 +++++++++++
 tb/tb_parallax_ctrl.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/parallax_pkg.sv
// parallax_ctrl shared definitions:
// geometry defaults, register map, CTRL bits, tracker states.
package parallax_pkg;

  localparam int LINE_W   = 1280;
  localparam int FRAME_H  = 720;
  localparam int CORR_MAX = 255;

  localparam logic [1:0] REG_TARGET   = 2'd0;
  localparam logic [1:0] REG_CTRL     = 2'd1;
  localparam logic [1:0] REG_STATUS   = 2'd2;
  localparam logic [1:0] REG_LINE_CNT = 2'd3;

  localparam int CTRL_RAMP    = 0;
  localparam int CTRL_FREEZE  = 1;
  localparam int CTRL_ERR_CLR = 2;

  typedef enum logic {
    GAP,
    LINE
  } line_state_t;

endpackage

// File: rtl/parallax_ctrl_if.sv
// Configuration register port of parallax_ctrl.
// Single-cycle write strobe, read data one cycle after the read strobe.
interface parallax_ctrl_if;
  logic [1:0]  cfg_address;
  logic        cfg_write;
  logic [15:0] cfg_writedata;
  logic        cfg_read;
  logic [15:0] cfg_readdata;

  modport master (
    output cfg_address, cfg_write,
    output cfg_writedata, cfg_read,
    input  cfg_readdata
  );

  modport slave (
    input  cfg_address, cfg_write,
    input  cfg_writedata, cfg_read,
    output cfg_readdata
  );
endinterface

// File: rtl/prlx_line_tracker.sv
// Follows sop/eop on the raw line stream, counts lines per frame
// and flags frame boundaries and protocol errors.
module prlx_line_tracker
  import parallax_pkg::*;
#(
  parameter int FRAME_H_P = parallax_pkg::FRAME_H
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        line_valid,
  input  logic        line_sop,
  input  logic        line_eop,
  input  logic        err_clr,
  output logic        in_line,
  output logic        frame_end,
  output logic        frame_start,
  output logic        err_sync,
  output logic [10:0] line_cnt
);

  localparam logic [10:0] LAST = 11'(FRAME_H_P - 1);

  line_state_t state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        acc_sop, acc_eop, done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= GAP;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    acc_sop     = line_valid & line_sop;
    acc_eop     = line_valid & line_eop;
    state_d     = state_q;
    done        = 1'b0;
    frame_start = 1'b0;
    // a new error in the clearing cycle is kept
    err_d       = err_q & ~err_clr;
    unique case (state_q)
      GAP: begin
        if (acc_sop) begin
          frame_start = (cnt_q == '0);
          if (acc_eop) done = 1'b1;
          else         state_d = LINE;
        end else if (acc_eop) begin
          err_d = 1'b1;
        end
      end
      LINE: begin
        if (acc_sop) err_d = 1'b1;
        if (acc_eop) begin
          done    = 1'b1;
          state_d = GAP;
        end
      end
    endcase
    frame_end = done && (cnt_q == LAST);
    cnt_d     = cnt_q;
    if (done) cnt_d = frame_end ? '0 : cnt_q + 11'd1;
  end

  assign in_line  = (state_q == LINE);
  assign err_sync = err_q;
  assign line_cnt = cnt_q;

endmodule

// File: rtl/parallax_ctrl.sv
// Frame-synchronous parallax offset controller: register file,
// readback and jump/ramp update applied only at frame end.
module parallax_ctrl
  import parallax_pkg::*;
#(
  parameter int LINE_W   = parallax_pkg::LINE_W,
  parameter int FRAME_H  = parallax_pkg::FRAME_H,
  parameter int CORR_MAX = parallax_pkg::CORR_MAX
) (
  input  logic            clk,
  input  logic            reset,
  parallax_ctrl_if.slave  cfg,
  input  logic            line_valid,
  input  logic            line_sop,
  input  logic            line_eop,
  output logic [7:0]      parallax_corr,
  output logic            frame_start,
  output logic            err_sync
);

  // offset must also stay below half a line
  localparam int LIM = (CORR_MAX < LINE_W / 2) ?
                       CORR_MAX : LINE_W / 2 - 1;
  localparam logic [7:0] LIM8 = 8'(LIM);

  logic [7:0]  target_q, target_d;
  logic [7:0]  corr_q, corr_d;
  logic        ramp_q, ramp_d;
  logic        freeze_q, freeze_d;
  logic [15:0] rdata_q, rdata_d;
  logic        wr_tgt, wr_ctrl, err_clr;
  logic        frame_end, in_line;
  logic [10:0] line_cnt;

  prlx_line_tracker #(
    .FRAME_H_P (FRAME_H)
  ) u_trk (
    .clk         (clk),
    .reset       (reset),
    .line_valid  (line_valid),
    .line_sop    (line_sop),
    .line_eop    (line_eop),
    .err_clr     (err_clr),
    .in_line     (in_line),
    .frame_end   (frame_end),
    .frame_start (frame_start),
    .err_sync    (err_sync),
    .line_cnt    (line_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      target_q <= '0;
      corr_q   <= '0;
      ramp_q   <= 1'b0;
      freeze_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      target_q <= target_d;
      corr_q   <= corr_d;
      ramp_q   <= ramp_d;
      freeze_q <= freeze_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    wr_tgt   = cfg.cfg_write &&
               (cfg.cfg_address == REG_TARGET);
    wr_ctrl  = cfg.cfg_write &&
               (cfg.cfg_address == REG_CTRL);
    err_clr  = wr_ctrl &&
               cfg.cfg_writedata[CTRL_ERR_CLR];
    target_d = target_q;
    ramp_d   = ramp_q;
    freeze_d = freeze_q;
    unique case (1'b1)
      wr_tgt: begin
        target_d = (cfg.cfg_writedata > 16'(LIM)) ?
                   LIM8 : cfg.cfg_writedata[7:0];
      end
      wr_ctrl: begin
        ramp_d   = cfg.cfg_writedata[CTRL_RAMP];
        freeze_d = cfg.cfg_writedata[CTRL_FREEZE];
      end
      default: ;
    endcase
  end

  // target_q is pre-write, so a same-cycle write waits a frame
  always_comb begin
    corr_d = corr_q;
    if (frame_end && !freeze_q) begin
      if (!ramp_q)                 corr_d = target_q;
      else if (corr_q < target_q)  corr_d = corr_q + 8'd1;
      else if (corr_q > target_q)  corr_d = corr_q - 8'd1;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (cfg.cfg_read) begin
      unique case (cfg.cfg_address)
        REG_TARGET:   rdata_d = {8'h0, target_q};
        REG_CTRL:     rdata_d = {14'h0, freeze_q, ramp_q};
        REG_STATUS:   rdata_d = {6'h0, err_sync,
                                 in_line, corr_q};
        REG_LINE_CNT: rdata_d = {5'h0, line_cnt};
      endcase
    end
  end

  assign parallax_corr    = corr_q;
  assign cfg.cfg_readdata = rdata_q;

endmodule

// File: tb/tb_parallax_ctrl.sv
// Scoreboard bench for parallax_ctrl: line-level reference model,
// directed scenarios then randomized frames and register traffic.
module tb_parallax_ctrl;
  import parallax_pkg::*;

  localparam int H = 8;

  typedef struct {
    int          c;
    logic [15:0] v;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       line_valid = 1'b0;
  logic       line_sop = 1'b0;
  logic       line_eop = 1'b0;
  logic [7:0] parallax_corr;
  logic       frame_start;
  logic       err_sync;

  parallax_ctrl_if cfg ();

  parallax_ctrl #(
    .FRAME_H (H)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg           (cfg),
    .line_valid    (line_valid),
    .line_sop      (line_sop),
    .line_eop      (line_eop),
    .parallax_corr (parallax_corr),
    .frame_start   (frame_start),
    .err_sync      (err_sync)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ev_t rd_q[$];
  ev_t corr_q[$];
  ev_t err_q[$];
  int  fs_q[$];

  // reference model, advanced one whole line event at a time
  logic [7:0] m_target = 0;
  logic [7:0] m_corr = 0;
  bit         m_ramp = 0, m_freeze = 0;
  bit         m_err = 0, m_inline = 0;
  int         m_lines = 0;

  bit          c_wr = 0, c_rd = 0, rnd = 0, done = 0;
  logic [1:0]  c_wa = 0, c_ra = 0;
  logic [15:0] c_wd = 0;

  int n_tests = 0, n_fail = 0;

  task automatic chk(string nm, longint act, longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic tick(bit v, bit s, bit e, bit fs,
                      bit nxt_in, bit dn, bit err_ev);
    logic [7:0]  pc;
    bit          pe;
    logic [15:0] rv;
    if (rnd && !c_wr && !c_rd) begin
      int r = $urandom_range(0, 11);
      if (r == 0) begin
        c_wr = 1; c_wa = REG_TARGET;
        c_wd = 16'($urandom_range(0, 400));
      end else if (r == 1) begin
        c_wr = 1; c_wa = 2'($urandom_range(1, 3));
        c_wd = 16'($urandom_range(0, 7));
      end else if (r < 4) begin
        c_rd = 1; c_ra = 2'($urandom_range(0, 3));
      end
    end
    cfg.cfg_write     = c_wr;
    cfg.cfg_address   = c_wr ? c_wa : c_ra;
    cfg.cfg_writedata = c_wd;
    cfg.cfg_read      = c_rd;
    if (c_wr && c_rd) cfg.cfg_address = c_wa;
    line_valid = v; line_sop = s; line_eop = e;
    if (c_rd) begin
      case (c_wr ? c_wa : c_ra)
        REG_TARGET: rv = {8'h0, m_target};
        REG_CTRL:   rv = {14'h0, m_freeze, m_ramp};
        REG_STATUS: rv = {6'h0, m_err, m_inline, m_corr};
        default:    rv = 16'(m_lines % H);
      endcase
      rd_q.push_back('{cyc + 1, rv});
    end
    if (fs) fs_q.push_back(cyc);
    pc = m_corr;
    pe = m_err;
    if (dn && ((m_lines + 1) % H) == 0 && !m_freeze) begin
      if (!m_ramp)                  m_corr = m_target;
      else if (m_corr < m_target)   m_corr = m_corr + 1;
      else if (m_corr > m_target)   m_corr = m_corr - 1;
    end
    if (c_wr) begin
      case (c_wa)
        REG_TARGET:
          m_target = (c_wd > 16'(CORR_MAX)) ?
                     8'(CORR_MAX) : c_wd[7:0];
        REG_CTRL: begin
          m_ramp   = c_wd[0];
          m_freeze = c_wd[1];
          if (c_wd[2]) m_err = 0;
        end
        default: ;
      endcase
    end
    if (err_ev) m_err = 1;
    if (dn) m_lines++;
    m_inline = nxt_in;
    if (m_corr != pc) corr_q.push_back('{cyc + 1, 16'(m_corr)});
    if (m_err != pe)  err_q.push_back('{cyc + 1, 16'(m_err)});
    c_wr = 0;
    c_rd = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic gap_tick();
    tick(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         0, 0, 0, 0);
  endtask

  task automatic wr(logic [1:0] a, logic [15:0] d);
    c_wr = 1; c_wa = a; c_wd = d;
    tick(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(logic [1:0] a);
    c_rd = 1; c_ra = a;
    tick(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic line(int len, int gap, bit ew = 0,
                      logic [15:0] ed = 0);
    bit f = (m_lines % H) == 0;
    if (len == 1) begin
      if (ew) begin c_wr = 1; c_wa = REG_TARGET; c_wd = ed; end
      tick(1, 1, 1, f, 0, 1, 0);
    end else begin
      tick(1, 1, 0, f, 1, 0, 0);
      for (int i = 1; i < len - 1; i++) begin
        bit v = ($urandom_range(0, 3) != 0);
        bit s = v ? ($urandom_range(0, 15) == 0)
                  : 1'($urandom_range(0, 1));
        bit e = v ? 1'b0 : 1'($urandom_range(0, 1));
        tick(v, s, e, 0, 1, 0, v & s);
      end
      if (ew) begin c_wr = 1; c_wa = REG_TARGET; c_wd = ed; end
      tick(1, 0, 1, 0, 0, 1, 0);
    end
    repeat (gap) gap_tick();
  endtask

  task automatic rline();
    line($urandom_range(1, 4), $urandom_range(0, 2));
  endtask

  task automatic finish_frame();
    do rline(); while (m_lines % H != 0);
  endtask

  initial begin
    cfg.cfg_address = 0; cfg.cfg_write = 0;
    cfg.cfg_writedata = 0; cfg.cfg_read = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    for (int a = 0; a < 4; a++) rd(2'(a));
    repeat (2) finish_frame();
    repeat (3) rline();
    wr(REG_TARGET, 40);
    finish_frame();
    rd(REG_STATUS);
    wr(REG_TARGET, 0);
    finish_frame();
    wr(REG_CTRL, 1);
    wr(REG_TARGET, 3);
    repeat (4) finish_frame();
    wr(REG_TARGET, 1);
    repeat (2) finish_frame();
    wr(REG_TARGET, 16'h12C);
    rd(REG_TARGET);
    wr(REG_CTRL, 2);
    rd(REG_CTRL);
    finish_frame();
    rd(REG_STATUS);
    wr(REG_CTRL, 0);
    wr(REG_TARGET, 1);
    while (m_lines % H != H - 1) rline();
    line(3, 1, 1, 10);
    rd(REG_TARGET);
    finish_frame();
    rd(REG_LINE_CNT);
    tick(1, 1, 0, (m_lines % H) == 0, 1, 0, 0);
    tick(1, 1, 0, 0, 1, 0, 1);
    tick(1, 0, 1, 0, 0, 1, 0);
    rd(REG_LINE_CNT);
    rd(REG_STATUS);
    tick(1, 0, 1, 0, 0, 0, 1);
    wr(REG_CTRL, 4);
    rd(REG_STATUS);
    rnd = 1;
    repeat (60) finish_frame();
    rnd = 0;
    repeat (4) tick(0, 0, 0, 0, 0, 0, 0);
    done = 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

  bit         rst_seen = 0;
  logic [7:0] last_corr = 0;
  bit         last_err = 0;

  always @(negedge clk) begin
    if (!reset) begin
      ev_t ev;
      bit  xfs;
      if (!rst_seen) begin
        rst_seen = 1;
        chk("reset_corr", parallax_corr, 0);
        chk("reset_err", err_sync, 0);
        chk("reset_rdata", cfg.cfg_readdata, 0);
        chk("reset_fs", frame_start, 0);
      end
      while (rd_q.size() != 0 && rd_q[0].c < cyc) begin
        ev = rd_q.pop_front();
        chk("rd_lost", cyc, ev.c);
      end
      if (rd_q.size() != 0 && rd_q[0].c == cyc) begin
        ev = rd_q.pop_front();
        chk("readdata", cfg.cfg_readdata, ev.v);
      end
      xfs = (fs_q.size() != 0 && fs_q[0] == cyc);
      if (xfs) void'(fs_q.pop_front());
      if (xfs || frame_start)
        chk("frame_start", frame_start, xfs);
      while (corr_q.size() != 0 && corr_q[0].c < cyc) begin
        ev = corr_q.pop_front();
        chk("corr_missed", parallax_corr, ev.v);
      end
      if (parallax_corr != last_corr) begin
        if (corr_q.size() == 0) begin
          chk("corr_unexpected", parallax_corr, last_corr);
        end else begin
          ev = corr_q.pop_front();
          chk("corr_cycle", cyc, ev.c);
          chk("corr_value", parallax_corr, ev.v);
        end
        last_corr = parallax_corr;
      end
      while (err_q.size() != 0 && err_q[0].c < cyc) begin
        ev = err_q.pop_front();
        chk("err_missed", err_sync, ev.v);
      end
      if (err_sync != last_err) begin
        if (err_q.size() == 0) begin
          chk("err_unexpected", err_sync, last_err);
        end else begin
          ev = err_q.pop_front();
          chk("err_cycle", cyc, ev.c);
          chk("err_value", err_sync, ev.v);
        end
        last_err = err_sync;
      end
      if (done) begin
        chk("final_corr", parallax_corr, m_corr);
        chk("final_err", err_sync, m_err);
        chk("pending_rd", rd_q.size(), 0);
        chk("pending_fs", fs_q.size(), 0);
        chk("pending_corr", corr_q.size(), 0);
        chk("pending_err", err_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
      end
    end
  end

endmodule
